// File: rtl/fixed_point_divider.sv
// Sequential unsigned fixed-point divider: result = floor((operand_1 << FBITS) / operand_2),
// one restoring-division quotient bit per clock, saturating on divide-by-zero and overflow.
module fixed_point_divider #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int ITER  = WIDTH + FBITS;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [ITER-1:0]  num_quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [ITER-1:0]  quo_nxt;
  logic             accept;
  logic             zero_req;
  logic             last;

  function automatic logic quo_overflow(input logic [ITER-1:0] q);
    return |q[ITER-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input logic [ITER-1:0] q);
    if (quo_overflow(q))
      return {WIDTH{1'b1}};
    return q[WIDTH-1:0];
  endfunction

  // The numerator drains out of the top of num_quo while quotient bits fill in from the
  // bottom, so after ITER shifts the register holds the full quotient.
  // rem is always < dvs, so WIDTH bits hold it; the trial value and the subtraction are
  // WIDTH+1 bits wide, and a borrow out of that subtraction means trial < dvs.
  always_comb begin
    trial    = {rem, num_quo[ITER-1]};
    diff     = trial - {1'b0, dvs};
    qbit     = ~diff[WIDTH];
    quo_nxt  = {num_quo[ITER-2:0], qbit};
    accept   = (state == IDLE) && start && (operand_2 != '0);
    zero_req = (state == IDLE) && start && (operand_2 == '0);
    last     = (state == RUN) && (count == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      num_quo     <= '0;
      rem         <= '0;
      dvs         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      ready       <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (accept) begin
        num_quo     <= {operand_1, {FBITS{1'b0}}};
        dvs         <= operand_2;
        rem         <= '0;
        count       <= CNT_W'(ITER);
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
      end else if (zero_req) begin
        result      <= {WIDTH{1'b1}};
        div_by_zero <= 1'b1;
        overflow    <= 1'b0;
        ready       <= 1'b1;
      end else if (state == RUN) begin
        rem     <= qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        num_quo <= quo_nxt;
        count   <= count - CNT_W'(1);
        if (last) begin
          result   <= saturate(quo_nxt);
          overflow <= quo_overflow(quo_nxt);
          ready    <= 1'b1;
        end
      end
    end
  end

endmodule
